// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback controller: opcodes,
// data width and FSM state encoding.
package alu_pkg;

  localparam int DW = 8;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_EQ   = 4'h8;
  localparam logic [3:0] OP_GT   = 4'h9;
  localparam logic [3:0] OP_LT   = 4'hA;
  localparam logic [3:0] OP_LAST = 4'hA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // Opcodes above OP_LAST are rejected with an err pulse.
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DW register file: two combinational read ports, one synchronous
// write port, all entries reset to zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int RA_W  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [RA_W-1:0] raddr1,
  output logic [DW-1:0]   rdata1,
  input  logic [RA_W-1:0] raddr2,
  output logic [DW-1:0]   rdata2
);

  logic [DW-1:0] mem_q [NREGS];
  logic [DW-1:0] mem_d [NREGS];

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];

  // Next-state of the storage: single write port.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of a combinational 8-bit ALU.
// Fixed IDLE -> EXEC -> WB sequence, one instruction in flight.
// Optional build macro ALU_ISSUE_PERF_EN adds perf_ops / perf_errs counters.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an instruction
//   EXEC  | operands presented to ALU, result captured at end of cycle
//   WB    | wb_valid high, register file and flags updated at end of cycle
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int RA_W  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [RA_W-1:0] in_rd,
  input  logic [RA_W-1:0] in_rs1,
  input  logic [RA_W-1:0] in_rs2,
  input  logic            in_imm_en,
  input  logic [DW-1:0]   in_imm,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [3:0]      alu_sel,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_zero,
  input  logic            alu_carry,
  output logic            wb_valid,
  output logic [RA_W-1:0] wb_rd,
  output logic [DW-1:0]   wb_data,
  output logic            flag_zero,
  output logic            flag_carry,
`ifdef ALU_ISSUE_PERF_EN
  output logic [15:0]     perf_ops,
  output logic [7:0]      perf_errs,
`endif
  output logic            err
);

  state_t            state_q, state_d;
  logic [DW-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]        sel_q, sel_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic              rz_q, rz_d, rc_q, rc_d;
  logic              fz_q, fz_d, fc_q, fc_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rf_rd1, rf_rd2;

  alu_regfile #(.NREGS(NREGS), .RA_W(RA_W)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (state_q == WB),
    .waddr  (rd_q),
    .wdata  (res_q),
    .raddr1 (in_rs1),
    .rdata1 (rf_rd1),
    .raddr2 (in_rs2),
    .rdata2 (rf_rd2)
  );

  assign in_ready   = (state_q == IDLE);
  assign wb_valid   = (state_q == WB);
  assign wb_rd      = rd_q;
  assign wb_data    = res_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = sel_q;
  assign flag_zero  = fz_q;
  assign flag_carry = fc_q;
  assign err        = err_q;

  // Next-state and datapath capture for the issue sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    res_d   = res_q;
    rz_d    = rz_q;
    rc_d    = rc_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!op_legal(in_op)) begin
            err_d = 1'b1;
          end else begin
            a_d     = rf_rd1;
            b_d     = in_imm_en ? in_imm : rf_rd2;
            sel_d   = in_op;
            rd_d    = in_rd;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        res_d   = alu_out;
        rz_d    = alu_zero;
        rc_d    = alu_carry;
        state_d = WB;
      end
      WB: begin
        fz_d    = rz_q;
        fc_d    = rc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      rz_q    <= 1'b0;
      rc_q    <= 1'b0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      rz_q    <= rz_d;
      rc_q    <= rc_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
      err_q   <= err_d;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] perf_ops_q, perf_ops_d;
  logic [7:0]  perf_errs_q, perf_errs_d;

  assign perf_ops  = perf_ops_q;
  assign perf_errs = perf_errs_q;

  // Writeback count wraps; error count saturates.
  always_comb begin
    perf_ops_d  = perf_ops_q;
    perf_errs_d = perf_errs_q;
    if (state_q == WB) perf_ops_d = perf_ops_q + 16'd1;
    if (err_d && (perf_errs_q != 8'hFF)) perf_errs_d = perf_errs_q + 8'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops_q  <= '0;
      perf_errs_q <= '0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_errs_q <= perf_errs_d;
    end
  end
`endif

endmodule
